// File: rtl/mcs_fpro_bridge.sv
// Registered bridge from the MicroBlaze MCS I/O bus to the FPro bus with one-hot chip selects.
// Optional error counter enabled by defining MCS_BRG_ERR_EN.
module mcs_fpro_bridge #(
    parameter logic [31:0] BRG_BASE   = 32'hC000_0000,
    parameter int unsigned ADDR_W     = 21,
    parameter int unsigned NUM_CS     = 2,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              io_addr_strobe,
    input  logic              io_read_strobe,
    input  logic              io_write_strobe,
    input  logic [3:0]        io_byte_enable,
    input  logic [31:0]       io_address,
    input  logic [31:0]       io_write_data,
    output logic [31:0]       io_read_data,
    output logic              io_ready,
    output logic [NUM_CS-1:0] fp_cs,
    output logic              fp_wr,
    output logic              fp_rd,
    output logic [ADDR_W-1:0] fp_addr,
    output logic [3:0]        fp_byte_en,
    output logic [31:0]       fp_wr_data,
    input  logic [31:0]       fp_rd_data,
    output logic [7:0]        err_cnt
);

    localparam int unsigned CS_W     = $clog2(NUM_CS);
    localparam int unsigned HI_LSB   = ADDR_W + 2 + CS_W;
    localparam logic [3:0]  LAT_INIT = 4'(RD_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StAck} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              dir_wr_q;
    logic [NUM_CS-1:0] cs_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic              strobe;
    logic              hit;
    logic              load;
    logic              capture;
    logic              miss_ack;
    logic [CS_W-1:0]   cs_idx;
    logic [NUM_CS-1:0] cs_dec;

    logic unused_bits;
    assign unused_bits = ^{io_addr_strobe, io_address[1:0]};

    assign strobe = io_read_strobe | io_write_strobe;
    assign hit    = (io_address[31:HI_LSB] == BRG_BASE[31:HI_LSB]);
    assign cs_idx = io_address[ADDR_W+2 +: CS_W];

    always_comb begin
        cs_dec         = '0;
        cs_dec[cs_idx] = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        capture  = 1'b0;
        miss_ack = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (strobe) begin
                    if (hit) begin
                        load    = 1'b1;
                        state_d = StReq;
                    end else begin
                        miss_ack = 1'b1;
                        state_d  = StAck;
                    end
                end
            end
            StReq: begin
                if (dir_wr_q) begin
                    state_d = StAck;
                end else begin
                    cnt_d   = LAT_INIT;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields are latched on acceptance and cleared when the access retires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_wr_q <= 1'b0;
            cs_q     <= '0;
            addr_q   <= '0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
        end else if (load) begin
            dir_wr_q <= io_write_strobe;
            cs_q     <= cs_dec;
            addr_q   <= io_address[ADDR_W+1:2];
            be_q     <= io_byte_enable;
            wdata_q  <= io_write_data;
        end else if (state_q == StAck) begin
            dir_wr_q <= 1'b0;
            cs_q     <= '0;
            addr_q   <= '0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= 32'd0;
        end else if (capture) begin
            rdata_q <= fp_rd_data;
        end else if (miss_ack) begin
            rdata_q <= 32'd0;
        end
    end

    assign io_read_data = rdata_q;
    assign io_ready     = (state_q == StAck);
    assign fp_cs        = cs_q;
    assign fp_addr      = addr_q;
    assign fp_byte_en   = be_q;
    assign fp_wr_data   = wdata_q;
    assign fp_wr        = (state_q == StReq) && dir_wr_q;
    assign fp_rd        = (state_q == StReq) && !dir_wr_q;

`ifdef MCS_BRG_ERR_EN
    logic [7:0] err_cnt_q;
    logic       err_evt;

    // Coincident error causes collapse into a single event.
    assign err_evt = (state_q == StIdle) ?
                     (strobe && (!hit || (io_read_strobe && io_write_strobe))) : strobe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= 8'd0;
        end else if (err_evt && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_mcs_fpro_bridge.sv
// Self-checking bench for mcs_fpro_bridge: directed cases, random transactions, error saturation.
module tb_mcs_fpro_bridge;

    localparam logic [31:0] BASE   = 32'hC000_0000;
    localparam int unsigned ADDR_W = 21;
    localparam int unsigned NUM_CS = 2;
    localparam int unsigned RD_LAT = 3;
    localparam int unsigned CS_W   = 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              io_addr_strobe = 1'b0;
    logic              io_read_strobe = 1'b0;
    logic              io_write_strobe = 1'b0;
    logic [3:0]        io_byte_enable = 4'd0;
    logic [31:0]       io_address = 32'd0;
    logic [31:0]       io_write_data = 32'd0;
    logic [31:0]       io_read_data;
    logic              io_ready;
    logic [NUM_CS-1:0] fp_cs;
    logic              fp_wr;
    logic              fp_rd;
    logic [ADDR_W-1:0] fp_addr;
    logic [3:0]        fp_byte_en;
    logic [31:0]       fp_wr_data;
    logic [31:0]       fp_rd_data = 32'd0;
    logic [7:0]        err_cnt;

    int tests = 0;
    int fails = 0;

    // Reference state: last value the MCS should see on reads, and the expected error count.
    logic [31:0] last_rd = 32'd0;
    int          err_exp = 0;

    mcs_fpro_bridge #(
        .BRG_BASE  (BASE),
        .ADDR_W    (ADDR_W),
        .NUM_CS    (NUM_CS),
        .RD_LATENCY(RD_LAT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .io_addr_strobe (io_addr_strobe),
        .io_read_strobe (io_read_strobe),
        .io_write_strobe(io_write_strobe),
        .io_byte_enable (io_byte_enable),
        .io_address     (io_address),
        .io_write_data  (io_write_data),
        .io_read_data   (io_read_data),
        .io_ready       (io_ready),
        .fp_cs          (fp_cs),
        .fp_wr          (fp_wr),
        .fp_rd          (fp_rd),
        .fp_addr        (fp_addr),
        .fp_byte_en     (fp_byte_en),
        .fp_wr_data     (fp_wr_data),
        .fp_rd_data     (fp_rd_data),
        .err_cnt        (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int err_model();
`ifdef MCS_BRG_ERR_EN
        return err_exp;
`else
        return 0;
`endif
    endfunction

    // One complete MCS access; glitch injects an illegal write strobe mid-transfer.
    task automatic issue(input logic [31:0] addr, input bit rd, input bit wr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] rdata, input bit glitch);
        bit          hit;
        int          exp_ready;
        int          ready_at;
        int          wr_n;
        int          rd_n;
        logic [31:0] exp_cs;
        logic [31:0] exp_addr;
        hit      = ((addr >> (ADDR_W + 2 + CS_W)) == (BASE >> (ADDR_W + 2 + CS_W)));
        exp_cs   = 32'd1 << ((addr >> (ADDR_W + 2)) % NUM_CS);
        exp_addr = (addr >> 2) % (32'd1 << ADDR_W);
        if (!hit)    exp_ready = 1;
        else if (wr) exp_ready = 2;
        else         exp_ready = 2 + RD_LAT;

        @(negedge clk);
        check("idle_cs", 32'(fp_cs), 32'd0);
        check("idle_addr", 32'(fp_addr), 32'd0);
        io_address      = addr;
        io_read_strobe  = rd;
        io_write_strobe = wr;
        io_write_data   = wdata;
        io_byte_enable  = be;
        io_addr_strobe  = 1'b1;
        fp_rd_data      = rdata;

        if (hit && rd && !wr) last_rd = rdata;
        if (!hit) last_rd = 32'd0;
        if ((!hit || (rd && wr) || glitch) && err_exp < 255) err_exp++;

        ready_at = 0;
        wr_n     = 0;
        rd_n     = 0;
        for (int c = 1; c <= 40 && ready_at == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                io_read_strobe  = 1'b0;
                io_write_strobe = 1'b0;
                io_addr_strobe  = 1'b0;
                io_address      = $urandom;
                io_write_data   = $urandom;
            end
            if (glitch && c == 2) io_write_strobe = 1'b1;
            if (glitch && c == 3) io_write_strobe = 1'b0;
            wr_n += int'(fp_wr);
            rd_n += int'(fp_rd);
            if (fp_wr || fp_rd) check("pulse_cycle", c, 1);
            if (hit && c <= exp_ready) begin
                check("fp_cs", 32'(fp_cs), exp_cs);
                check("fp_addr", 32'(fp_addr), exp_addr);
                check("fp_byte_en", 32'(fp_byte_en), 32'(be));
                check("fp_wr_data", fp_wr_data, wdata);
            end
            if (io_ready) begin
                ready_at = c;
                check("io_read_data", io_read_data, last_rd);
                check("err_cnt", 32'(err_cnt), 32'(err_model()));
            end
        end
        io_write_strobe = 1'b0;
        check("ready_cycle", ready_at, exp_ready);
        check("fp_wr_pulses", wr_n, (hit && wr) ? 1 : 0);
        check("fp_rd_pulses", rd_n, (hit && !wr) ? 1 : 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          kind;

        #1;
        check("rst_ready", 32'(io_ready), 32'd0);
        check("rst_rdata", io_read_data, 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        issue(32'hC000_0010, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
        issue(32'hC080_0008, 1'b1, 1'b0, 32'd0, 4'h3, 32'h1234_5678, 1'b0);
        issue(32'hC000_0020, 1'b0, 1'b1, 32'h0BAD_F00D, 4'h1, 32'd0, 1'b0);
        issue(32'h4000_0000, 1'b1, 1'b0, 32'd0, 4'hF, 32'hFFFF_FFFF, 1'b0);
        issue(32'hC000_0000, 1'b1, 1'b1, 32'hCAFE_0001, 4'hC, 32'h5555_AAAA, 1'b0);
        issue(32'hC080_0100, 1'b1, 1'b0, 32'd0, 4'hF, 32'hA5A5_0F0F, 1'b1);

        // Reset in the middle of a read wait: everything clears and no acknowledge appears.
        @(negedge clk);
        io_address     = 32'hC000_0040;
        io_read_strobe = 1'b1;
        fp_rd_data     = 32'h7777_7777;
        @(negedge clk);
        io_read_strobe = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rstw_ready", 32'(io_ready), 32'd0);
        check("rstw_fp_rd", 32'(fp_rd), 32'd0);
        check("rstw_cs", 32'(fp_cs), 32'd0);
        check("rstw_addr", 32'(fp_addr), 32'd0);
        check("rstw_rdata", io_read_data, 32'd0);
        check("rstw_err", 32'(err_cnt), 32'd0);
        last_rd = 32'd0;
        err_exp = 0;
        repeat (4) begin
            @(negedge clk);
            check("rstw_no_ready", 32'(io_ready), 32'd0);
        end
        reset_n = 1'b1;
        issue(32'hC080_0004, 1'b1, 1'b0, 32'd0, 4'hF, 32'h1357_9BDF, 1'b0);

        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            if ($urandom_range(0, 9) < 7) a[31:24] = 8'hC0;
            kind = $urandom_range(0, 9);
            issue(a, kind != 1, kind < 5, $urandom, 4'($urandom), $urandom, 1'b0);
        end

        for (int i = 0; i < 300; i++) begin
            issue(32'h1000_0000 + 32'(i * 4), 1'b1, 1'b0, 32'd0, 4'hF, 32'hFFFF_0000, 1'b0);
        end
        @(negedge clk);
        check("err_sat", 32'(err_cnt), 32'(err_model()));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
